// File: rtl/seg_scan_decoder.sv
// Purpose : recovers BCD digits from a multiplexed, active-low 4-digit 7-segment scan bus.
// Latency : a pattern held from edge k is visible on the outputs after edge k+STABLE_CYCLES.
// Backpr. : none; the scan bus is observed passively and update is a one-cycle strobe.
// Ports   : clk, rst (async, active-high); an[3:0], seg[6:0], dp (active-low inputs);
//           digits[15:0] (BCD nibble per digit), valid/err/dp_out[3:0] per digit, update strobe.
module seg_scan_decoder #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  an,
    input  logic [6:0]  seg,
    input  logic        dp,
    output logic [15:0] digits,
    output logic [3:0]  valid,
    output logic [3:0]  err,
    output logic [3:0]  dp_out,
    output logic        update
);

    typedef enum logic [1:0] {IDLE, TRACK, HOLD} state_t;

    localparam logic [7:0]  STABLE_MAX = 8'(STABLE_CYCLES);
    localparam logic [23:0] AGE_MAX    = 24'(TIMEOUT_CYCLES);
    localparam logic [23:0] AGE_LAST   = AGE_MAX - 24'd1;

    // Input sample and the sample taken one edge earlier, for the identity test.
    logic [3:0]  r_an,      r_prev_an;
    logic [6:0]  r_seg,     r_prev_seg;
    logic        r_dp,      r_prev_dp;

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [23:0] r_age [4];
    logic [15:0] r_digits;
    logic [3:0]  r_valid;
    logic [3:0]  r_err;
    logic [3:0]  r_dp_out;
    logic        r_update;

    logic [3:0]  w_low;
    logic        w_legal;
    logic        w_same;
    logic [1:0]  w_sel;
    logic [3:0]  w_val;
    logic        w_glyph;
    logic        w_blank;
    logic        w_capture;

    // Legal scan slot: exactly one anode driven low.
    assign w_low   = ~r_an;
    assign w_legal = (w_low != 4'd0) && ((w_low & (w_low - 4'd1)) == 4'd0);
    assign w_same  = (r_an == r_prev_an) && (r_seg == r_prev_seg) && (r_dp == r_prev_dp);

    always_comb begin
        w_sel = 2'd0;
        case (w_low)
            4'b0010: w_sel = 2'd1;
            4'b0100: w_sel = 2'd2;
            4'b1000: w_sel = 2'd3;
            default: w_sel = 2'd0;
        endcase
    end

    always_comb begin
        w_val   = 4'd0;
        w_glyph = 1'b1;
        case (r_seg)
            7'b1000000: w_val = 4'd0;
            7'b1111001: w_val = 4'd1;
            7'b0100100: w_val = 4'd2;
            7'b0110000: w_val = 4'd3;
            7'b0011001: w_val = 4'd4;
            7'b0010010: w_val = 4'd5;
            7'b0000010: w_val = 4'd6;
            7'b1111000: w_val = 4'd7;
            7'b0000000: w_val = 4'd8;
            7'b0010000: w_val = 4'd9;
            default:    w_glyph = 1'b0;
        endcase
    end

    assign w_blank = (r_seg == 7'b1111111);

    // The identical sample that would bring the count up to STABLE_CYCLES captures.
    assign w_capture = (r_state == TRACK) && w_legal && w_same &&
                       ((r_cnt + 8'd1) >= STABLE_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_an       <= 4'hF;
            r_seg      <= 7'h7F;
            r_dp       <= 1'b1;
            r_prev_an  <= 4'hF;
            r_prev_seg <= 7'h7F;
            r_prev_dp  <= 1'b1;
        end else begin
            r_an       <= an;
            r_seg      <= seg;
            r_dp       <= dp;
            r_prev_an  <= r_an;
            r_prev_seg <= r_seg;
            r_prev_dp  <= r_dp;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= 8'd0;
            r_digits <= 16'd0;
            r_valid  <= 4'd0;
            r_err    <= 4'd0;
            r_dp_out <= 4'd0;
            r_update <= 1'b0;
            for (int i = 0; i < 4; i++) r_age[i] <= 24'd0;
        end else begin
            r_update <= w_capture;

            case (r_state)
                IDLE: begin
                    if (w_legal) begin
                        r_state <= TRACK;
                        r_cnt   <= 8'd1;
                    end else begin
                        r_cnt   <= 8'd0;
                    end
                end
                TRACK: begin
                    if (!w_legal) begin
                        r_state <= IDLE;
                        r_cnt   <= 8'd0;
                    end else if (!w_same) begin
                        r_cnt   <= 8'd1;
                    end else if (w_capture) begin
                        r_state <= HOLD;
                        r_cnt   <= STABLE_MAX;
                    end else begin
                        r_cnt   <= r_cnt + 8'd1;
                    end
                end
                HOLD: begin
                    if (!w_legal) begin
                        r_state <= IDLE;
                        r_cnt   <= 8'd0;
                    end else if (!w_same) begin
                        r_state <= TRACK;
                        r_cnt   <= 8'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= 8'd0;
                end
            endcase

            // Capture takes priority over an expiring age on the same digit.
            for (int i = 0; i < 4; i++) begin
                if (w_capture && (w_sel == 2'(i))) begin
                    r_age[i]          <= 24'd0;
                    r_digits[4*i +: 4] <= w_glyph ? w_val : 4'd0;
                    r_valid[i]        <= w_glyph;
                    r_err[i]          <= !w_glyph && !w_blank;
                    r_dp_out[i]       <= ~r_dp;
                end else begin
                    if (r_age[i] < AGE_MAX) r_age[i] <= r_age[i] + 24'd1;
                    // This edge brings the age to the timeout value.
                    if (r_age[i] >= AGE_LAST) r_valid[i] <= 1'b0;
                end
            end
        end
    end

    assign digits = r_digits;
    assign valid  = r_valid;
    assign err    = r_err;
    assign dp_out = r_dp_out;
    assign update = r_update;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Purpose : directed scenarios for seg_scan_decoder with a capture scoreboard.
// Latency : expected capture strobe lands STABLE_CYCLES+1 negedges after the drive negedge.
// Backpr. : none; the monitor pops one expectation per update strobe.
module tb_seg_scan_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [15:0] digits,  digits_t;
    logic [3:0]  valid,   valid_t;
    logic [3:0]  err,     err_t;
    logic [3:0]  dp_out,  dp_out_t;
    logic        update,  update_t;

    always #5 clk = ~clk;

    seg_scan_decoder dut (
        .clk(clk), .rst(rst), .an(an), .seg(seg), .dp(dp),
        .digits(digits), .valid(valid), .err(err), .dp_out(dp_out), .update(update)
    );

    seg_scan_decoder #(.STABLE_CYCLES(4), .TIMEOUT_CYCLES(16)) dut_t (
        .clk(clk), .rst(rst), .an(an), .seg(seg), .dp(dp),
        .digits(digits_t), .valid(valid_t), .err(err_t), .dp_out(dp_out_t), .update(update_t)
    );

    typedef struct {
        int       d;
        logic [3:0] val;
        logic     v;
        logic     e;
        logic     p;
        int       cyc;
    } exp_t;

    exp_t sb[$];
    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   upd_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic expect_cap(input int d, input logic [3:0] val, input logic v,
                              input logic e, input logic p, input int at);
        exp_t x;
        x.d = d; x.val = val; x.v = v; x.e = e; x.p = p; x.cyc = at;
        sb.push_back(x);
    endtask

    // Monitor: every update strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (update === 1'b1) begin
            exp_t x;
            upd_cnt++;
            chk("update_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                x = sb.pop_front();
                chk("cap_cycle", 32'(cyc), 32'(x.cyc));
                chk("cap_digit", 32'(digits[4*x.d +: 4]), 32'(x.val));
                chk("cap_valid", 32'(valid[x.d]), 32'(x.v));
                chk("cap_err",   32'(err[x.d]), 32'(x.e));
                chk("cap_dp",    32'(dp_out[x.d]), 32'(x.p));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    logic [6:0] glyph [4];
    int n;

    initial begin
        glyph[0] = 7'b1111001;
        glyph[1] = 7'b0100100;
        glyph[2] = 7'b0110000;
        glyph[3] = 7'b0011001;

        rst = 1'b1; an = 4'hF; seg = 7'h7F; dp = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_digits", 32'(digits), 32'h0);
        chk("rst_valid",  32'(valid),  32'h0);
        chk("rst_err",    32'(err),    32'h0);
        chk("rst_dp_out", 32'(dp_out), 32'h0);
        chk("rst_update", 32'(update), 32'h0);
        @(negedge clk); rst = 1'b0;

        // Digit 0 = 2, basic capture latency.
        @(negedge clk);
        an = 4'b1110; seg = 7'b0100100; dp = 1'b1;
        expect_cap(0, 4'd2, 1'b1, 1'b0, 1'b0, cyc + 5);
        repeat (8) @(negedge clk);
        chk("t1_valid",  32'(valid), 32'b0001);
        chk("t1_err",    32'(err),   32'b0000);
        chk("t1_digit",  32'(digits[3:0]), 32'd2);
        chk("t1_upd_cnt", 32'(upd_cnt), 32'd1);

        // Short-lived 5 is discarded, then 4 captured on digit 1.
        @(negedge clk);
        an = 4'b1101; seg = 7'b0010010;
        repeat (3) @(negedge clk);
        seg = 7'b0011001;
        expect_cap(1, 4'd4, 1'b1, 1'b0, 1'b0, cyc + 5);
        repeat (8) @(negedge clk);
        chk("t2_digit",   32'(digits[7:4]), 32'd4);
        chk("t2_valid",   32'(valid), 32'b0011);
        chk("t2_upd_cnt", 32'(upd_cnt), 32'd2);

        // Non-glyph with decimal point on digit 2, then an illegal anode pair.
        @(negedge clk);
        an = 4'b1011; seg = 7'b0001000; dp = 1'b0;
        expect_cap(2, 4'd0, 1'b0, 1'b1, 1'b1, cyc + 5);
        repeat (8) @(negedge clk);
        chk("t3_err",    32'(err),    32'b0100);
        chk("t3_valid",  32'(valid),  32'b0011);
        chk("t3_dp_out", 32'(dp_out), 32'b0100);
        an = 4'b1001;
        repeat (10) @(negedge clk);
        chk("t3_no_update", 32'(upd_cnt), 32'd3);
        chk("t3_digits",    32'(digits),  32'h0042);

        // Reset three samples into a stable 7 on digit 0.
        @(negedge clk);
        an = 4'b1110; seg = 7'b1111000; dp = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t4_rst_digits", 32'(digits), 32'h0);
        chk("t4_rst_valid",  32'(valid),  32'h0);
        chk("t4_rst_err",    32'(err),    32'h0);
        chk("t4_rst_dp_out", 32'(dp_out), 32'h0);
        chk("t4_rst_update", 32'(update), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        n = cyc;
        expect_cap(0, 4'd7, 1'b1, 1'b0, 1'b0, n + 5);
        repeat (4) @(negedge clk);
        chk("t4_no_early_cap", 32'(upd_cnt), 32'd3);
        repeat (4) @(negedge clk);
        chk("t4_upd_cnt", 32'(upd_cnt), 32'd4);
        chk("t4_digits",  32'(digits),  32'h0007);

        // Full scan rotation 1,2,3,4.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            an  = ~(4'b0001 << k);
            seg = glyph[k];
            expect_cap(k, 4'(k + 1), 1'b1, 1'b0, 1'b0, cyc + 5);
            repeat (7) @(negedge clk);
        end
        repeat (2) @(negedge clk);
        chk("t5_digits",  32'(digits),  32'h4321);
        chk("t5_valid",   32'(valid),   32'hF);
        chk("t5_upd_cnt", 32'(upd_cnt), 32'd8);

        // Staleness on the short-timeout instance: digit 3 = 9, then bus goes blank.
        @(negedge clk);
        an = 4'b0111; seg = 7'b0010000; dp = 1'b1;
        n = cyc;
        expect_cap(3, 4'd9, 1'b1, 1'b0, 1'b0, n + 5);
        repeat (5) @(negedge clk);
        chk("t6_cap_update", 32'(update_t),   32'd1);
        chk("t6_cap_valid",  32'(valid_t[3]), 32'd1);
        an = 4'hF;
        repeat (15) @(negedge clk);
        chk("t6_valid_before", 32'(valid_t[3]), 32'd1);
        @(negedge clk);
        chk("t6_valid_stale",  32'(valid_t[3]), 32'd0);
        chk("t6_digit_kept",   32'(digits_t[15:12]), 32'd9);
        chk("t6_main_valid",   32'(valid[3]), 32'd1);

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
